// File: rtl/dcache_sram_nway_pkg.sv
// Shared definitions for the N-way data-cache storage: default geometry,
// commit operation encoding and the way-index width helper.
package dcache_sram_nway_pkg;

    localparam int DEF_NUM_SETS = 16;
    localparam int DEF_NUM_WAYS = 2;
    localparam int DEF_TAG_W    = 23;
    localparam int DEF_LINE_W   = 256;

    typedef enum logic [1:0] {
        OP_NONE      = 2'd0,
        OP_REFILL    = 2'd1,
        OP_WRITE_HIT = 2'd2,
        OP_READ_HIT  = 2'd3
    } op_e;

    function automatic int way_width(input int ways);
        return (ways > 2) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_sram_nway_lru_set.sv
// True-LRU helper for one set: picks the replacement way and computes the
// ages that result from touching a given way.
module dcache_lru_set
    import dcache_sram_nway_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int WAY_W    = way_width(NUM_WAYS)
) (
    input  logic [NUM_WAYS*WAY_W-1:0] ages,
    input  logic [NUM_WAYS-1:0]       valid,
    input  logic [WAY_W-1:0]          touch_way,
    output logic [WAY_W-1:0]          victim_way,
    output logic [NUM_WAYS*WAY_W-1:0] ages_next
);

    logic [WAY_W-1:0] inval_way_s;
    logic [WAY_W-1:0] lru_way_s;
    logic [WAY_W-1:0] touch_age_s;
    logic [WAY_W-1:0] age_s;

    // Downward scans leave the lowest qualifying way selected.
    always_comb begin
        inval_way_s = '0;
        lru_way_s   = '0;
        touch_age_s = '0;
        age_s       = '0;
        ages_next   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            age_s       = ages[w*WAY_W +: WAY_W];
            inval_way_s = valid[w] ? inval_way_s : WAY_W'(w);
            lru_way_s   = (age_s == WAY_W'(NUM_WAYS - 1)) ? WAY_W'(w) : lru_way_s;
            touch_age_s = (WAY_W'(w) == touch_way) ? age_s : touch_age_s;
        end
        victim_way = (&valid) ? lru_way_s : inval_way_s;
        for (int w = 0; w < NUM_WAYS; w++) begin
            age_s = ages[w*WAY_W +: WAY_W];
            ages_next[w*WAY_W +: WAY_W] = (WAY_W'(w) == touch_way) ? WAY_W'(0) :
                                          (age_s < touch_age_s)    ? age_s + WAY_W'(1) :
                                                                     age_s;
        end
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage: combinational lookup and victim
// selection, clocked refill / byte-enable write / LRU update.
module dcache_sram_nway
    import dcache_sram_nway_pkg::*;
#(
    parameter  int NUM_SETS = DEF_NUM_SETS,
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    parameter  int TAG_W    = DEF_TAG_W,
    parameter  int LINE_W   = DEF_LINE_W,
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = way_width(NUM_WAYS),
    localparam int BE_W     = LINE_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [SET_W-1:0]  addr_i,
    input  logic [TAG_W+1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic              refill_i,
    output logic              hit_o,
    output logic [WAY_W-1:0]  hit_way_o,
    output logic [WAY_W-1:0]  victim_way_o,
    output logic [TAG_W+1:0]  tag_o,
    output logic [LINE_W-1:0] data_o
);

    logic [TAG_W-1:0]  tag_r   [NUM_SETS][NUM_WAYS];
    logic              valid_r [NUM_SETS][NUM_WAYS];
    logic              dirty_r [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  age_r   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] data_r  [NUM_SETS][NUM_WAYS];

    logic [NUM_WAYS-1:0]       match_s;
    logic [NUM_WAYS-1:0]       valid_set_s;
    logic [NUM_WAYS*WAY_W-1:0] ages_set_s;
    logic [NUM_WAYS*WAY_W-1:0] ages_next_s;
    logic                      hit_s;
    logic [WAY_W-1:0]          hit_way_s;
    logic [WAY_W-1:0]          victim_way_s;
    logic [WAY_W-1:0]          sel_way_s;
    logic [WAY_W-1:0]          touch_way_s;
    logic [LINE_W-1:0]         wr_line_s;
    op_e                       op_s;

    // Tag compare across the addressed set; the lowest matching way wins.
    always_comb begin
        match_s     = '0;
        valid_set_s = '0;
        ages_set_s  = '0;
        hit_way_s   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            valid_set_s[w] = valid_r[addr_i][w];
            match_s[w]     = valid_r[addr_i][w] && (tag_r[addr_i][w] == tag_i[TAG_W-1:0]);
            ages_set_s[w*WAY_W +: WAY_W] = age_r[addr_i][w];
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_way_s = match_s[w] ? WAY_W'(w) : hit_way_s;
        end
        hit_s = |match_s;
    end

    dcache_lru_set #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
    ) u_lru (
        .ages       (ages_set_s),
        .valid      (valid_set_s),
        .touch_way  (touch_way_s),
        .victim_way (victim_way_s),
        .ages_next  (ages_next_s)
    );

    // Resolve the commit operation and assemble the line to be written.
    always_comb begin
        sel_way_s   = hit_s ? hit_way_s : victim_way_s;
        touch_way_s = (refill_i && !hit_s) ? victim_way_s : hit_way_s;
        wr_line_s   = data_i;
        if (!enable_i) begin
            op_s = OP_NONE;
        end else if (refill_i) begin
            op_s = OP_REFILL;
        end else if (hit_s) begin
            op_s = write_i ? OP_WRITE_HIT : OP_READ_HIT;
        end else begin
            op_s = OP_NONE;
        end
        if (op_s == OP_WRITE_HIT) begin
            for (int k = 0; k < BE_W; k++) begin
                wr_line_s[8*k +: 8] = be_i[k] ? data_i[8*k +: 8] : data_r[addr_i][hit_way_s][8*k +: 8];
            end
        end else begin
            wr_line_s = data_i;
        end
    end

    assign hit_o        = hit_s;
    assign hit_way_o    = hit_way_s;
    assign victim_way_o = victim_way_s;
    assign tag_o        = {valid_r[addr_i][sel_way_s], dirty_r[addr_i][sel_way_s], tag_r[addr_i][sel_way_s]};
    assign data_o       = data_r[addr_i][sel_way_s];

    // Tag, status and age state; every set starts with age equal to way index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_r[s][w]   <= '0;
                    valid_r[s][w] <= 1'b0;
                    dirty_r[s][w] <= 1'b0;
                    age_r[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            case (op_s)
                OP_REFILL: begin
                    tag_r[addr_i][touch_way_s]   <= tag_i[TAG_W-1:0];
                    valid_r[addr_i][touch_way_s] <= tag_i[TAG_W+1];
                    dirty_r[addr_i][touch_way_s] <= tag_i[TAG_W];
                end
                OP_WRITE_HIT: dirty_r[addr_i][touch_way_s] <= 1'b1;
                default: ;
            endcase
            if (op_s != OP_NONE) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_r[addr_i][w] <= ages_next_s[w*WAY_W +: WAY_W];
                end
            end
        end
    end

    // Line storage has no reset so it can map onto SRAM.
    always_ff @(posedge clk_i) begin
        if (op_s == OP_REFILL || op_s == OP_WRITE_HIT) begin
            data_r[addr_i][touch_way_s] <= wr_line_s;
        end
    end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Scoreboard bench for dcache_sram_nway (4 ways): directed scenarios plus
// random traffic against a recency-list reference model.
module tb_dcache_sram_nway;

    localparam int NUM_SETS = 16;
    localparam int NUM_WAYS = 4;
    localparam int TAG_W    = 23;
    localparam int LINE_W   = 256;
    localparam int SET_W    = 4;
    localparam int WAY_W    = 2;
    localparam int BE_W     = LINE_W / 8;

    localparam logic [TAG_W-1:0] TAG_A = 23'h00AAAA;
    localparam logic [TAG_W-1:0] TAG_B = 23'h00BBBB;
    localparam logic [TAG_W-1:0] TAG_C = 23'h00CCCC;
    localparam logic [TAG_W-1:0] TAG_D = 23'h00DDDD;
    localparam logic [TAG_W-1:0] TAG_E = 23'h00EEEE;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [SET_W-1:0]  addr_i = '0;
    logic [TAG_W+1:0]  tag_i = '0;
    logic [LINE_W-1:0] data_i = '0;
    logic [BE_W-1:0]   be_i = '0;
    logic              enable_i = 1'b0;
    logic              write_i = 1'b0;
    logic              refill_i = 1'b0;
    logic              hit_o;
    logic [WAY_W-1:0]  hit_way_o;
    logic [WAY_W-1:0]  victim_way_o;
    logic [TAG_W+1:0]  tag_o;
    logic [LINE_W-1:0] data_o;

    dcache_sram_nway #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .TAG_W    (TAG_W),
        .LINE_W   (LINE_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .addr_i       (addr_i),
        .tag_i        (tag_i),
        .data_i       (data_i),
        .be_i         (be_i),
        .enable_i     (enable_i),
        .write_i      (write_i),
        .refill_i     (refill_i),
        .hit_o        (hit_o),
        .hit_way_o    (hit_way_o),
        .victim_way_o (victim_way_o),
        .tag_o        (tag_o),
        .data_o       (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic              hit;
        logic [WAY_W-1:0]  hit_way;
        logic [WAY_W-1:0]  victim;
        logic [TAG_W+1:0]  tag;
        logic [LINE_W-1:0] data;
        bit                data_ok;
        string             name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: per-set entries plus a most-recent-first list of ways.
    logic [TAG_W-1:0]  m_tag   [NUM_SETS][NUM_WAYS];
    bit                m_valid [NUM_SETS][NUM_WAYS];
    bit                m_dirty [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] m_data  [NUM_SETS][NUM_WAYS];
    int                m_order [NUM_SETS][NUM_WAYS];

    function automatic void m_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                m_tag[s][w]   = '0;
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        end
    endfunction

    function automatic int m_hit_way(input int s, input logic [TAG_W-1:0] t);
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        end
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!m_valid[s][w]) return w;
        end
        return m_order[s][NUM_WAYS-1];
    endfunction

    function automatic int m_age(input int s, input int w);
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (m_order[s][i] == w) return i;
        end
        return -1;
    endfunction

    function automatic void m_touch(input int s, input int w);
        int p;
        p = m_age(s, w);
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endfunction

    function automatic exp_t m_expect(input int s, input logic [TAG_W+1:0] t);
        exp_t e;
        int   hw;
        int   sel;
        hw        = m_hit_way(s, t[TAG_W-1:0]);
        e.hit     = (hw >= 0);
        e.hit_way = (hw >= 0) ? WAY_W'(hw) : '0;
        e.victim  = WAY_W'(m_victim(s));
        sel       = (hw >= 0) ? hw : m_victim(s);
        e.tag     = {m_valid[s][sel], m_dirty[s][sel], m_tag[s][sel]};
        e.data    = m_data[s][sel];
        e.data_ok = m_valid[s][sel];
        e.name    = "";
        return e;
    endfunction

    task automatic m_commit();
        int s;
        int hw;
        int tw;
        s  = int'(addr_i);
        hw = m_hit_way(s, tag_i[TAG_W-1:0]);
        if (!enable_i) return;
        if (refill_i) begin
            tw = (hw >= 0) ? hw : m_victim(s);
            m_tag[s][tw]   = tag_i[TAG_W-1:0];
            m_valid[s][tw] = tag_i[TAG_W+1];
            m_dirty[s][tw] = tag_i[TAG_W];
            m_data[s][tw]  = data_i;
            m_touch(s, tw);
        end else if (hw >= 0) begin
            if (write_i) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (be_i[k]) m_data[s][hw][8*k +: 8] = data_i[8*k +: 8];
                end
                m_dirty[s][hw] = 1'b1;
            end
            m_touch(s, hw);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input bit en, input bit wr, input bit rf, input int s,
                         input logic [TAG_W+1:0] t, input logic [LINE_W-1:0] d,
                         input logic [BE_W-1:0] be, input string nm);
        exp_t e;
        enable_i = en;
        write_i  = wr;
        refill_i = rf;
        addr_i   = SET_W'(s);
        tag_i    = t;
        data_i   = d;
        be_i     = be;
        e        = m_expect(s, t);
        e.name   = nm;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        m_commit();
        #1;
    endtask

    // Monitor: outputs are combinational, so every pending expectation is
    // checked on the falling edge, then the age state is audited.
    always @(negedge clk_i) begin
        int      age_bad;
        int      seen;
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            if (hit_o !== mon_e.hit || hit_way_o !== mon_e.hit_way ||
                victim_way_o !== mon_e.victim || tag_o !== mon_e.tag) begin
                n_fail++;
                $display("FAIL %s lookup: got hit=%0b way=%0d victim=%0d tag=%h, want hit=%0b way=%0d victim=%0d tag=%h",
                         mon_e.name, hit_o, hit_way_o, victim_way_o, tag_o,
                         mon_e.hit, mon_e.hit_way, mon_e.victim, mon_e.tag);
            end
            if (mon_e.data_ok) begin
                n_tests++;
                if (data_o !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL %s data: got %h want %h", mon_e.name, data_o, mon_e.data);
                end
            end
        end
        if (rst_ni) begin
            n_tests++;
            age_bad = -1;
            for (int s = 0; s < NUM_SETS; s++) begin
                seen = 0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    seen |= (1 << int'(dut.age_r[s][w]));
                    if (int'(dut.age_r[s][w]) != m_age(s, w) && age_bad < 0) age_bad = s;
                end
                if (seen != (1 << NUM_WAYS) - 1 && age_bad < 0) age_bad = s;
            end
            if (age_bad >= 0) begin
                n_fail++;
                $display("FAIL ages set %0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", age_bad,
                         dut.age_r[age_bad][0], dut.age_r[age_bad][1], dut.age_r[age_bad][2], dut.age_r[age_bad][3],
                         m_age(age_bad, 0), m_age(age_bad, 1), m_age(age_bad, 2), m_age(age_bad, 3));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [LINE_W-1:0] line_a;
        logic [LINE_W-1:0] ones;
        logic [TAG_W-1:0]  pool [6];
        int                r;
        int                s;
        m_reset();
        ones = '1;
        #12 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset state lookup.
        apply(1'b1, 1'b0, 1'b0, 3, {2'b00, 23'h000012}, '0, '0, "reset_read");
        #1;
        chk("reset_hit", LINE_W'(hit_o), LINE_W'(0));
        chk("reset_victim", LINE_W'(victim_way_o), LINE_W'(0));
        chk("reset_valid", LINE_W'(tag_o[TAG_W+1]), LINE_W'(0));
        step();

        // Fill set 5 with A..D, make B least recent, refill E over it.
        line_a = rand_line();
        apply(1'b1, 1'b0, 1'b1, 5, {2'b10, TAG_A}, line_a, '0, "fill_a"); step();
        apply(1'b1, 1'b0, 1'b1, 5, {2'b10, TAG_B}, rand_line(), '0, "fill_b"); step();
        apply(1'b1, 1'b0, 1'b1, 5, {2'b10, TAG_C}, rand_line(), '0, "fill_c"); step();
        apply(1'b1, 1'b0, 1'b1, 5, {2'b10, TAG_D}, rand_line(), '0, "fill_d"); step();
        apply(1'b1, 1'b0, 1'b0, 5, {2'b00, TAG_A}, '0, '0, "read_a"); step();
        apply(1'b1, 1'b0, 1'b1, 5, {2'b10, TAG_E}, rand_line(), '0, "fill_e");
        #1;
        chk("fill_e_victim", LINE_W'(victim_way_o), LINE_W'(1));
        chk("fill_e_victim_tag", LINE_W'(tag_o), LINE_W'({2'b10, TAG_B}));
        step();
        apply(1'b1, 1'b0, 1'b0, 5, {2'b00, TAG_E}, '0, '0, "read_e");
        #1;
        chk("read_e_way", LINE_W'({hit_o, hit_way_o}), LINE_W'({1'b1, 2'd1}));
        step();

        // Byte-enabled write hit on A.
        apply(1'b1, 1'b1, 1'b0, 5, {2'b00, TAG_A}, ones, 32'h0000_000F, "write_a"); step();
        apply(1'b1, 1'b0, 1'b0, 5, {2'b00, TAG_A}, '0, '0, "read_a_after_write");
        #1;
        chk("write_a_data", data_o, {line_a[LINE_W-1:32], 32'hFFFF_FFFF});
        chk("write_a_dirty", LINE_W'(tag_o[TAG_W]), LINE_W'(1));
        step();

        // Write miss leaves state alone; then make dirty C the LRU victim.
        apply(1'b1, 1'b1, 1'b0, 7, {2'b00, 23'h000777}, ones, '1, "write_miss"); step();
        apply(1'b1, 1'b0, 1'b0, 7, {2'b00, 23'h000777}, '0, '0, "read_after_miss");
        #1;
        chk("write_miss_valid", LINE_W'(tag_o[TAG_W+1]), LINE_W'(0));
        step();
        apply(1'b1, 1'b1, 1'b0, 5, {2'b00, TAG_C}, rand_line(), 32'hF0F0_0001, "write_c"); step();
        apply(1'b1, 1'b0, 1'b0, 5, {2'b00, TAG_D}, '0, '0, "read_d"); step();
        apply(1'b1, 1'b0, 1'b0, 5, {2'b00, TAG_A}, '0, '0, "read_a2"); step();
        apply(1'b1, 1'b0, 1'b0, 5, {2'b00, TAG_E}, '0, '0, "read_e2"); step();
        apply(1'b1, 1'b0, 1'b0, 5, {2'b00, 23'h00FFFF}, '0, '0, "dirty_victim");
        #1;
        chk("dirty_victim_way", LINE_W'({hit_o, victim_way_o}), LINE_W'({1'b0, 2'd2}));
        chk("dirty_victim_tag", LINE_W'(tag_o), LINE_W'({2'b11, TAG_C}));
        step();

        // Refill with write also set on a hit replaces the hit way in place.
        apply(1'b1, 1'b1, 1'b1, 5, {2'b10, TAG_A}, rand_line(), '1, "refill_on_hit"); step();
        apply(1'b1, 1'b0, 1'b0, 5, {2'b00, TAG_A}, '0, '0, "read_a_refilled");
        #1;
        chk("refill_hit_entry", LINE_W'({hit_way_o, tag_o}), LINE_W'({2'd0, 2'b10, TAG_A}));
        step();

        // Refill with valid=0 invalidates the target.
        apply(1'b1, 1'b0, 1'b1, 2, {2'b10, 23'h000055}, rand_line(), '0, "fill_x"); step();
        apply(1'b1, 1'b0, 1'b1, 2, {2'b01, 23'h000055}, rand_line(), '0, "inval_x"); step();
        apply(1'b1, 1'b0, 1'b0, 2, {2'b00, 23'h000055}, '0, '0, "read_x");
        #1;
        chk("inval_x_hit", LINE_W'(hit_o), LINE_W'(0));
        step();

        // Asynchronous reset pulse between edges.
        apply(1'b0, 1'b0, 1'b0, 5, {2'b00, TAG_A}, '0, '0, "idle_before_rst");
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        m_reset();
        #1;
        chk("rst_pulse_hit", LINE_W'(hit_o), LINE_W'(0));
        chk("rst_pulse_tag", LINE_W'(tag_o), LINE_W'(0));
        chk("rst_pulse_ages", LINE_W'({dut.age_r[5][3], dut.age_r[5][2], dut.age_r[5][1], dut.age_r[5][0]}),
            LINE_W'({2'd3, 2'd2, 2'd1, 2'd0}));
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Random traffic over a few sets and a small tag pool.
        for (int i = 0; i < 6; i++) pool[i] = TAG_W'(23'h000100 + i);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            s = $urandom_range(0, 3);
            apply(($urandom_range(0, 9) != 0), (r >= 35 && r < 70), (r < 35), s,
                  {($urandom_range(0, 7) != 0), 1'($urandom), pool[$urandom_range(0, 5)]},
                  rand_line(), BE_W'($urandom), "random");
            step();
        end

        enable_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("scoreboard_drained", LINE_W'(sb_q.size()), LINE_W'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
